// File: rtl/can_rx_frame_decoder_pkg.sv
// Shared CAN receive definitions: decoder states, CRC-15 polynomial, frame
// tail lengths and the payload length rule.
package can_defs;

    localparam logic [14:0] CAN_CRC_POLY = 15'h4599;
    localparam logic [5:0]  EOF_LEN      = 6'd7;
    localparam logic [5:0]  INTEG_LEN    = 6'd11;

    typedef enum logic [4:0] {
        INTEGRATE, IDLE, ID_A, SRR_RTR, IDE, ID_B, RTR_EXT, R1, R0, DLC,
        DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, WAIT_IDLE
    } state_t;

    // Payload bits carried by a frame; remote frames carry none, DLC saturates at 8 bytes.
    function automatic logic [6:0] data_bits(input logic rtr, input logic [3:0] dlc);
        if (rtr)
            return 7'd0;
        else if (dlc > 4'd8)
            return 7'd64;
        else
            return {dlc, 3'b000};
    endfunction

endpackage

// File: rtl/can_rx_frame_decoder_crc.sv
// Serial CRC-15 accumulator; init clears, enable shifts in one destuffed bit.
module can_crc15
    import can_defs::*;
#(
    parameter logic [14:0] CRC_POLY = CAN_CRC_POLY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        enable,
    input  logic        bit_in,
    output logic [14:0] crc_out
);

    logic [14:0] r_crc;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            r_crc <= '0;
        else if (init)
            r_crc <= '0;
        else if (enable)
            r_crc <= {r_crc[13:0], 1'b0} ^ ((bit_in ^ r_crc[14]) ? CRC_POLY : 15'd0);
    end

    assign crc_out = r_crc;

endmodule

// File: rtl/can_rx_frame_decoder.sv
// CAN receive path: destuffing, field decode, CRC check, ACK drive and
// shadowed frame outputs. Decoding advances only on sample_point strobes.
module can_rx_frame_decoder
    import can_defs::*;
#(
    parameter logic [14:0] CRC_POLY = CAN_CRC_POLY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_point,
    input  logic        sampled_bit,
    output logic [28:0] rx_id,
    output logic        rx_ide,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        send_ack,
    output logic        stuff_error,
    output logic        crc_error,
    output logic        form_error,
    output logic        rx_busy,
    output state_t      dbg_state
);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_last;
    logic [2:0]  r_same;
    logic [10:0] r_id_a;
    logic [17:0] r_id_b;
    logic        r_ide, r_rtr;
    logic [3:0]  r_dlc;
    logic [63:0] r_data;
    logic [14:0] r_crc_rx;
    logic [28:0] r_rx_id;
    logic        r_rx_ide, r_rx_rtr;
    logic [3:0]  r_rx_dlc;
    logic [63:0] r_rx_data;
    logic        r_valid, r_ack, r_stuff_err, r_crc_err, r_form_err, r_busy;

    logic [14:0] w_crc;
    logic [14:0] w_crc_rx_next;
    logic [3:0]  w_dlc_next;
    logic [6:0]  w_len_dlc, w_len;
    logic        w_in_stuff, w_stuff_bit, w_crc_en, w_crc_init;

    // CRC_DEL is included so a stuff bit following the last CRC bit is removed.
    assign w_in_stuff    = r_state inside {ID_A, SRR_RTR, IDE, ID_B, RTR_EXT, R1, R0,
                                           DLC, DATA, CRC, CRC_DEL};
    assign w_stuff_bit   = w_in_stuff && (r_same == 3'd5);
    assign w_crc_init    = sample_point && (r_state == IDLE) && !sampled_bit;
    assign w_crc_en      = sample_point && !w_stuff_bit &&
                           (r_state inside {ID_A, SRR_RTR, IDE, ID_B, RTR_EXT, R1, R0, DLC, DATA});
    assign w_crc_rx_next = {r_crc_rx[13:0], sampled_bit};
    assign w_dlc_next    = {r_dlc[2:0], sampled_bit};
    assign w_len_dlc     = data_bits(r_rtr, w_dlc_next);
    assign w_len         = data_bits(r_rtr, r_dlc);

    // SOF is dominant, so feeding it into a zero seed leaves zero; init alone covers it.
    can_crc15 #(.CRC_POLY(CRC_POLY)) u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (w_crc_init),
        .enable  (w_crc_en),
        .bit_in  (sampled_bit),
        .crc_out (w_crc)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= INTEGRATE;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_same      <= '0;
            r_id_a      <= '0;
            r_id_b      <= '0;
            r_ide       <= 1'b0;
            r_rtr       <= 1'b0;
            r_dlc       <= '0;
            r_data      <= '0;
            r_crc_rx    <= '0;
            r_rx_id     <= '0;
            r_rx_ide    <= 1'b0;
            r_rx_rtr    <= 1'b0;
            r_rx_dlc    <= '0;
            r_rx_data   <= '0;
            r_valid     <= 1'b0;
            r_ack       <= 1'b0;
            r_stuff_err <= 1'b0;
            r_crc_err   <= 1'b0;
            r_form_err  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_stuff_err <= 1'b0;
            r_crc_err   <= 1'b0;
            r_form_err  <= 1'b0;
            if (sample_point) begin
                // A stuff bit opens a new run of equal bits.
                if (w_in_stuff) begin
                    if (w_stuff_bit || (sampled_bit != r_last)) begin
                        r_last <= sampled_bit;
                        r_same <= 3'd1;
                    end else begin
                        r_same <= r_same + 3'd1;
                    end
                end
                if (w_stuff_bit) begin
                    if (sampled_bit == r_last) begin
                        r_stuff_err <= 1'b1;
                        r_state     <= WAIT_IDLE;
                        r_cnt       <= '0;
                        r_ack       <= 1'b0;
                    end
                end else begin
                    case (r_state)
                        INTEGRATE, WAIT_IDLE: begin
                            if (!sampled_bit) begin
                                r_cnt <= '0;
                            end else if (r_cnt == INTEG_LEN - 6'd1) begin
                                r_state <= IDLE;
                                r_cnt   <= '0;
                                r_busy  <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                        IDLE: begin
                            if (!sampled_bit) begin
                                r_state <= ID_A;
                                r_busy  <= 1'b1;
                                r_cnt   <= '0;
                                r_last  <= 1'b0;
                                r_same  <= 3'd1;
                                r_id_a  <= '0;
                                r_id_b  <= '0;
                                r_ide   <= 1'b0;
                                r_rtr   <= 1'b0;
                                r_dlc   <= '0;
                                r_data  <= '0;
                            end
                        end
                        ID_A: begin
                            r_id_a <= {r_id_a[9:0], sampled_bit};
                            if (r_cnt == 6'd10) begin
                                r_state <= SRR_RTR;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                        SRR_RTR: begin
                            r_rtr   <= sampled_bit;
                            r_state <= IDE;
                        end
                        IDE: begin
                            r_ide   <= sampled_bit;
                            r_state <= sampled_bit ? ID_B : R0;
                        end
                        ID_B: begin
                            r_id_b <= {r_id_b[16:0], sampled_bit};
                            if (r_cnt == 6'd17) begin
                                r_state <= RTR_EXT;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                        RTR_EXT: begin
                            r_rtr   <= sampled_bit;
                            r_state <= R1;
                        end
                        R1: r_state <= R0;
                        R0: begin
                            r_state <= DLC;
                            r_cnt   <= '0;
                        end
                        DLC: begin
                            r_dlc <= w_dlc_next;
                            if (r_cnt == 6'd3) begin
                                r_cnt   <= '0;
                                r_state <= (w_len_dlc == 7'd0) ? CRC : DATA;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                        DATA: begin
                            r_data[6'd63 - r_cnt] <= sampled_bit;
                            if ({1'b0, r_cnt} == w_len - 7'd1) begin
                                r_state <= CRC;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                        CRC: begin
                            r_crc_rx <= w_crc_rx_next;
                            if (r_cnt == 6'd14) begin
                                r_cnt <= '0;
                                if (w_crc_rx_next == w_crc) begin
                                    r_state <= CRC_DEL;
                                end else begin
                                    r_crc_err <= 1'b1;
                                    r_state   <= WAIT_IDLE;
                                end
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                        CRC_DEL: begin
                            if (sampled_bit) begin
                                r_ack   <= 1'b1;
                                r_state <= ACK;
                            end else begin
                                r_form_err <= 1'b1;
                                r_state    <= WAIT_IDLE;
                                r_cnt      <= '0;
                            end
                        end
                        ACK: begin
                            r_ack   <= 1'b0;
                            r_state <= ACK_DEL;
                        end
                        ACK_DEL: begin
                            r_cnt <= '0;
                            if (sampled_bit) begin
                                r_state <= EOF;
                            end else begin
                                r_form_err <= 1'b1;
                                r_state    <= WAIT_IDLE;
                            end
                        end
                        EOF: begin
                            if (r_cnt == EOF_LEN - 6'd1) begin
                                r_state <= IDLE;
                                r_cnt   <= '0;
                                r_busy  <= 1'b0;
                            end else if (!sampled_bit) begin
                                r_form_err <= 1'b1;
                                r_state    <= WAIT_IDLE;
                                r_cnt      <= '0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                                if (r_cnt == EOF_LEN - 6'd2) begin
                                    r_valid   <= 1'b1;
                                    r_rx_id   <= r_ide ? {r_id_a, r_id_b} : {18'd0, r_id_a};
                                    r_rx_ide  <= r_ide;
                                    r_rx_rtr  <= r_rtr;
                                    r_rx_dlc  <= r_dlc;
                                    r_rx_data <= r_data;
                                end
                            end
                        end
                        default: r_state <= INTEGRATE;
                    endcase
                end
            end
        end
    end

    assign rx_id       = r_rx_id;
    assign rx_ide      = r_rx_ide;
    assign rx_rtr      = r_rx_rtr;
    assign rx_dlc      = r_rx_dlc;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_valid;
    assign send_ack    = r_ack;
    assign stuff_error = r_stuff_err;
    assign crc_error   = r_crc_err;
    assign form_error  = r_form_err;
    assign rx_busy     = r_busy;
    assign dbg_state   = r_state;

endmodule

// File: doc/can_rx_frame_decoder.md
CAN_RX_FRAME_DECODER -- requirements
Module: can_rx_frame_decoder

Interface
REQ-001 SHALL have parameter: CRC_POLY, 15'h4599, CRC-15 generator polynomial.
REQ-002 SHALL have port: clk  in  1  system clock.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: sample_point  in  1  one-clk strobe, bus bit valid.
REQ-005 SHALL have port: sampled_bit  in  1  bus level at sample point (0 = dominant).
REQ-006 SHALL have port: rx_id  out  29  received ID; standard ID in [10:0], [28:11] zero.
REQ-007 SHALL have port: rx_ide  out  1  extended-frame flag.
REQ-008 SHALL have port: rx_rtr  out  1  remote-frame flag.
REQ-009 SHALL have port: rx_dlc  out  4  received DLC, raw.
REQ-010 SHALL have port: rx_data  out  64  payload; byte 0 in [63:56], unused bytes zero.
REQ-011 SHALL have port: rx_valid  out  1  one-clk pulse, frame accepted.
REQ-012 SHALL have port: send_ack  out  1  drive dominant in ACK slot.
REQ-013 SHALL have ports: stuff_error, crc_error, form_error  out  1 each  one-clk error pulses.
REQ-014 SHALL have port: rx_busy  out  1  high from SOF until return to IDLE.

Function
REQ-015 SHALL change state, counters and CRC only on clk edges with sample_point=1.
REQ-016 SHALL use states: INTEGRATE, IDLE, ID_A, SRR_RTR, IDE, ID_B, RTR_EXT, R1, R0, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, WAIT_IDLE.
REQ-017 SHALL leave INTEGRATE/WAIT_IDLE for IDLE after 11 consecutive recessive samples; a dominant sample restarts the count.
REQ-018 SHALL treat a dominant sample in IDLE as SOF: enter ID_A and seed CRC = 0.
REQ-019 SHALL use the sequence: ID_A (11) -> SRR_RTR -> IDE; IDE=0 -> R0 -> DLC; IDE=1 -> ID_B (18) -> RTR_EXT -> R1 -> R0 -> DLC (4) -> DATA -> CRC (15).
REQ-020 SHALL load the first 11 ID bits into rx_id[28:18] for extended frames and rx_id[10:0] for standard frames, MSB first.
REQ-021 SHALL take data length = 0 if RTR, else min(DLC,8)*8; skip DATA when the length is 0.
REQ-022 SHALL destuff from SOF through the last CRC bit: after 5 equal destuffed bits, drop the next bit; if it equals them, pulse stuff_error.
REQ-023 SHALL feed every destuffed bit SOF..last data bit into CRC: crc = (crc<<1) ^ ((bit^crc[14]) ? CRC_POLY : 0).
REQ-024 SHALL compare the received CRC with the computed CRC at the last CRC bit; on mismatch, pulse crc_error with send_ack held low.
REQ-025 SHALL require recessive CRC_DEL, ACK_DEL and EOF bits 1..6; a dominant sample pulses form_error.
REQ-026 SHALL raise send_ack the clk after the CRC_DEL sample when CRC matched, and drop it the clk after the ACK sample.
REQ-027 SHALL pulse rx_valid the clk after EOF bit 6 is sampled; EOF bit 7 is consumed, then IDLE.
REQ-028 SHALL hold rx_* outputs in shadow registers, updated only with rx_valid; they hold between frames.
REQ-029 SHALL, on any error pulse, go to WAIT_IDLE, drop send_ack and produce no rx_valid.

Reset
REQ-030 SHALL, on reset, set: state INTEGRATE; all outputs 0; CRC, counters and stuff history cleared.
REQ-031 SHALL, on reset mid-frame, discard the partial frame; no rx_valid or error pulse follows.

Structure
REQ-032 SHALL keep the state enum and the CRC_POLY and EOF/integration length constants in the shared can_defs package.
REQ-033 SHALL implement CRC in one sub-module, can_crc15 (clk, rst_n, init, enable, bit_in, crc_out).

Verification
REQ-034 SHALL cover: standard ID 0x157, DLC 4, data 55 55 55 55, correct CRC, sample_point every 8 clk -> send_ack during ACK, rx_valid once, rx_id=0x157, rx_data=0x55555555_00000000.
REQ-035 SHALL cover: extended ID 0x1ABCDEF, DLC 8, data 11..88 -> rx_ide=1, rx_id=0x1ABCDEF, rx_data=0x1122334455667788.
REQ-036 SHALL cover: RTR frame, DLC 4 -> no DATA bits consumed, rx_rtr=1, rx_dlc=4, rx_data=0.
REQ-037 SHALL cover: six consecutive dominant bits inside ID_A -> stuff_error pulse, WAIT_IDLE, no rx_valid; the next valid frame is accepted after 11 recessive bits.
REQ-038 SHALL cover: one CRC bit inverted -> crc_error, send_ack stays 0, no rx_valid; separately, dominant EOF bit 3 -> form_error.
REQ-039 SHALL cover: rst_n asserted during DATA -> outputs 0 next clk; INTEGRATE needs 11 recessive bits before SOF is accepted.
